// File: rtl/mux_pkg.sv
// Shared constants and helpers for the mux/demux family.
package mux_pkg;

  localparam int ERR_CNT_W = 8;

  // Select width for a lane count; never narrower than one bit.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry lane buffer: a push always wins, so push and pop together replace the word without a bubble.
module demux_slot #(
  parameter int BIT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [BIT_WIDTH-1:0] word,
  output logic [BIT_WIDTH-1:0] data,
  output logic                 full
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (push) begin
      full <= 1'b1;
      data <= word;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_buf.sv
// Registered handshaked demultiplexer: one producer stream steered to DEPTH single-entry lanes.
module demux_buf
  import mux_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int DEPTH     = 2,
  parameter int SEL_WIDTH = clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [BIT_WIDTH-1:0]       dataIn,
  input  logic [SEL_WIDTH-1:0]       sel,
  input  logic                       inValid,
  output logic                       inReady,
  output logic [BIT_WIDTH*DEPTH-1:0] dataOut,
  output logic [DEPTH-1:0]           outValid,
  input  logic [DEPTH-1:0]           outReady,
  output logic [ERR_CNT_W-1:0]       errCount
);

  localparam logic [SEL_WIDTH:0] DEPTH_LIM = (SEL_WIDTH + 1)'(DEPTH);

  logic [DEPTH-1:0] full;
  logic [DEPTH-1:0] push;
  logic [DEPTH-1:0] pop;
  logic             in_range;
  logic             lane_ready;
  logic             accept;

  assign in_range = ({1'b0, sel} < DEPTH_LIM);

  // Loop decode avoids indexing past the last lane for non-power-of-two DEPTH.
  always_comb begin
    lane_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel == SEL_WIDTH'(i)) lane_ready = ~full[i] | outReady[i];
    end
  end

  assign inReady  = in_range ? lane_ready : 1'b1;
  assign accept   = inValid & inReady;
  assign pop      = full & outReady;
  assign outValid = full;

  for (genvar g = 0; g < DEPTH; g++) begin : g_lane
    assign push[g] = accept & (sel == SEL_WIDTH'(g));

    demux_slot #(
      .BIT_WIDTH(BIT_WIDTH)
    ) u_slot (
      .clk  (clk),
      .rst_n(rst_n),
      .push (push[g]),
      .pop  (pop[g]),
      .word (dataIn),
      .data (dataOut[g*BIT_WIDTH +: BIT_WIDTH]),
      .full (full[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errCount <= '0;
    end else if (accept && !in_range && (errCount != '1)) begin
      errCount <= errCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_buf.sv
// Bench for demux_buf: a 4-lane and a 3-lane instance, directed cases plus a per-lane scoreboard.
module tb_demux_buf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  d4_data = '0;
  logic [1:0]  d4_sel = '0;
  logic        d4_valid = 1'b0;
  logic [3:0]  d4_ordy = '0;
  logic        in_ready4;
  logic [31:0] data_out4;
  logic [3:0]  out_valid4;
  logic [7:0]  err_count4;

  logic [7:0]  d3_data = '0;
  logic [1:0]  d3_sel = '0;
  logic        d3_valid = 1'b0;
  logic [2:0]  d3_ordy = '0;
  logic        in_ready3;
  logic [23:0] data_out3;
  logic [2:0]  out_valid3;
  logic [7:0]  err_count3;

  demux_buf #(.BIT_WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .dataIn(d4_data), .sel(d4_sel), .inValid(d4_valid),
    .inReady(in_ready4), .dataOut(data_out4), .outValid(out_valid4),
    .outReady(d4_ordy), .errCount(err_count4)
  );

  demux_buf #(.BIT_WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .dataIn(d3_data), .sel(d3_sel), .inValid(d3_valid),
    .inReady(in_ready3), .dataOut(data_out3), .outValid(out_valid3),
    .outReady(d3_ordy), .errCount(err_count3)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] lane4(input int i);
    return data_out4[i*8 +: 8];
  endfunction

  // Reference model: each lane queue holds the words the 4-lane DUT should be buffering.
  logic [7:0] sbq [4][$];
  logic       last_acc = 1'b0;

  always @(negedge rst_n) begin
    for (int i = 0; i < 4; i++) sbq[i].delete();
  end

  always @(posedge clk) begin
    logic       exp_rdy;
    logic [3:0] exp_vld;
    logic [7:0] exp_word;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) exp_vld[i] = (sbq[i].size() != 0);
      exp_rdy = !exp_vld[d4_sel] || d4_ordy[d4_sel];
      chk("sb_out_valid", 32'(out_valid4), 32'(exp_vld));
      if (d4_valid) chk("sb_in_ready", 32'(in_ready4), 32'(exp_rdy));
      for (int i = 0; i < 4; i++) begin
        if (exp_vld[i] && d4_ordy[i]) begin
          exp_word = sbq[i].pop_front();
          chk("sb_lane_data", 32'(lane4(i)), 32'(exp_word));
        end
      end
      last_acc = d4_valid && exp_rdy;
      if (last_acc) sbq[d4_sel].push_back(d4_data);
    end else begin
      last_acc = 1'b0;
    end
  end

  task automatic drive4(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
    d4_valid = v;
    d4_sel   = s;
    d4_data  = d;
    d4_ordy  = r;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int total;
    #3;
    chk("rst_out_valid", 32'(out_valid4), 32'h0);
    chk("rst_data_out", data_out4, 32'h0);
    chk("rst_in_ready", 32'(in_ready4), 32'h1);
    chk("rst_err_count", 32'(err_count3), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Push 0xA5 to lane 2 with every consumer stalled.
    next_cycle();
    drive4(1'b1, 2'd2, 8'hA5, 4'b0000);
    @(negedge clk);
    chk("push_a5_ready", 32'(in_ready4), 32'h1);
    next_cycle();
    drive4(1'b1, 2'd2, 8'h3C, 4'b0000);
    @(negedge clk);
    chk("lane2_valid", 32'(out_valid4), 32'h4);
    chk("lane2_a5", 32'(lane4(2)), 32'hA5);
    chk("lane2_stall", 32'(in_ready4), 32'h0);

    // Pop and push lane 2 in the same cycle.
    next_cycle();
    drive4(1'b1, 2'd2, 8'h3C, 4'b0100);
    @(negedge clk);
    chk("passthru_ready", 32'(in_ready4), 32'h1);
    next_cycle();
    drive4(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    chk("passthru_valid", 32'(out_valid4), 32'h4);
    chk("passthru_3c", 32'(lane4(2)), 32'h3C);

    // Drain lane 2, then stall lane 1 while lane 0 still accepts.
    next_cycle();
    drive4(1'b1, 2'd1, 8'h5A, 4'b0100);
    next_cycle();
    drive4(1'b1, 2'd0, 8'h11, 4'b0000);
    @(negedge clk);
    chk("lane0_ready", 32'(in_ready4), 32'h1);
    next_cycle();
    drive4(1'b1, 2'd1, 8'hEE, 4'b0000);
    @(negedge clk);
    chk("indep_valid", 32'(out_valid4), 32'h3);
    chk("indep_lane0", 32'(lane4(0)), 32'h11);
    chk("indep_lane1", 32'(lane4(1)), 32'h5A);
    chk("lane1_stall", 32'(in_ready4), 32'h0);

    // Out-of-range selects on the 3-lane instance saturate the error counter.
    next_cycle();
    d3_valid = 1'b1;
    d3_sel   = 2'd3;
    d3_ordy  = 3'b000;
    drive4(1'b0, 2'd0, 8'h00, 4'b0000);
    for (int i = 0; i < 300; i++) begin
      d3_data = 8'(i);
      @(negedge clk);
      chk("oor_ready", 32'(in_ready3), 32'h1);
      chk("oor_no_valid", 32'(out_valid3), 32'h0);
      chk("oor_count", 32'(err_count3), (i < 255) ? 32'(i) : 32'd255);
      next_cycle();
    end
    d3_valid = 1'b0;
    @(negedge clk);
    chk("oor_final", 32'(err_count3), 32'd255);

    // Fill the remaining lanes, then reset mid-stream.
    next_cycle();
    drive4(1'b1, 2'd2, 8'h22, 4'b0000);
    next_cycle();
    drive4(1'b1, 2'd3, 8'h33, 4'b0000);
    next_cycle();
    drive4(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    chk("fill_valid", 32'(out_valid4), 32'hF);
    chk("fill_data", data_out4, 32'h33225A11);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid4), 32'h0);
    chk("midrst_data", data_out4, 32'h0);
    chk("midrst_err", 32'(err_count3), 32'h0);
    chk("midrst_ready", 32'(in_ready4), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive4(1'b1, 2'd1, 8'h99, 4'b0000);
    @(negedge clk);
    chk("post_rst_empty", 32'(out_valid4), 32'h0);
    next_cycle();
    drive4(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid4), 32'h2);
    chk("post_rst_data", 32'(lane4(1)), 32'h99);

    // Random streaming; a stalled word is held until accepted.
    for (int c = 0; c < 600; c++) begin
      next_cycle();
      if (!(d4_valid && !last_acc)) begin
        d4_valid = ($urandom_range(0, 3) != 0);
        d4_sel   = 2'($urandom_range(0, 3));
        d4_data  = 8'($urandom);
      end
      d4_ordy = 4'($urandom);
    end
    next_cycle();
    drive4(1'b0, 2'd0, 8'h00, 4'b1111);
    repeat (3) next_cycle();
    @(negedge clk);
    total = 0;
    for (int i = 0; i < 4; i++) total += sbq[i].size();
    chk("drain_empty", 32'(total), 32'h0);
    chk("drain_valid", 32'(out_valid4), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
